// File: rtl/imm_gen_pipe_if.sv
// Handshaked request/result bundle for the registered immediate generator.
// The slave modport is the generator side; master is the decode stage driving it.
interface imm_gen_pipe_if #(
   parameter int XLEN = 64
) ();
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [2:0]      in_sel;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic            out_noimm;

   modport master (
      output in_valid, in_instr, in_sel, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_noimm
   );

   modport slave (
      input  in_valid, in_instr, in_sel, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_noimm
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV64IM immediate generator: format select/decode, sign/zero extension to XLEN,
// result held in a 2-entry skid buffer (or a single register when SKID=0).
module imm_gen_pipe #(
   parameter int XLEN        = 64,
   parameter int AUTO_DECODE = 1,
   parameter int SKID        = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   imm_gen_pipe_if.slave io_bus
);

   localparam logic [2:0] FMT_NONE  = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_U     = 3'd2;
   localparam logic [2:0] FMT_S     = 3'd3;
   localparam logic [2:0] FMT_B     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_SHAMT = 3'd6;
   localparam logic [2:0] FMT_ZIMM  = 3'd7;

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

   function automatic logic [2:0] f_auto_fmt(input logic [31:0] instr);
      logic [2:0] f3;
      f3 = instr[14:12];
      case (instr[6:0])
         7'b0010011, 7'b0011011:
            f_auto_fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SHAMT : FMT_I;
         7'b0000011, 7'b1100111: f_auto_fmt = FMT_I;
         7'b0110111, 7'b0010111: f_auto_fmt = FMT_U;
         7'b0100011:             f_auto_fmt = FMT_S;
         7'b1100011:             f_auto_fmt = FMT_B;
         7'b1101111:             f_auto_fmt = FMT_J;
         7'b1110011:             f_auto_fmt = f3[2] ? FMT_ZIMM : FMT_I;
         default:                f_auto_fmt = FMT_NONE;
      endcase
   endfunction

   // Sized casts of signed operands sign-extend, so one expression serves XLEN 32 and 64.
   function automatic logic [XLEN-1:0] f_imm(input logic [31:0] i, input logic [2:0] fmt,
                                             input logic wide);
      case (fmt)
         FMT_I:     f_imm = XLEN'($signed(i[31:20]));
         FMT_S:     f_imm = XLEN'($signed({i[31:25], i[11:7]}));
         FMT_B:     f_imm = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
         FMT_U:     f_imm = XLEN'($signed({i[31:12], 12'b0}));
         FMT_J:     f_imm = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
         FMT_SHAMT: f_imm = wide ? XLEN'(i[25:20]) : XLEN'(i[24:20]);
         FMT_ZIMM:  f_imm = XLEN'(i[19:15]);
         default:   f_imm = '0;
      endcase
   endfunction

   logic [2:0]      w_fmt;
   logic            w_wide;
   logic [XLEN-1:0] w_imm;
   logic            w_noimm;
   logic            w_in_ready;
   logic            w_accept;
   logic            w_drain;
   logic            w_load_new;
   logic            w_load_tail;
   logic            w_promote;
   state_t          w_nxt_state;

   state_t          r_state;
   logic            r_in_ready;
   logic [XLEN-1:0] r_head_imm;
   logic [2:0]      r_head_fmt;
   logic            r_head_noimm;
   logic [XLEN-1:0] r_tail_imm;
   logic [2:0]      r_tail_fmt;
   logic            r_tail_noimm;

   // The 6-bit shamt applies only to the 64-bit non-W shift opcode (or any explicit SHAMT at XLEN=64).
   always_comb begin
      w_fmt   = (AUTO_DECODE != 0) ? f_auto_fmt(io_bus.in_instr) : io_bus.in_sel;
      w_wide  = (XLEN == 64) &&
                ((AUTO_DECODE == 0) || (io_bus.in_instr[6:0] == 7'b0010011));
      w_imm   = f_imm(io_bus.in_instr, w_fmt, w_wide);
      w_noimm = (w_fmt == FMT_NONE);
   end

   assign w_in_ready = (SKID != 0) ? r_in_ready
                                   : (!i_rst && (r_state != ST_ONE || io_bus.out_ready));
   assign w_accept   = io_bus.in_valid && w_in_ready;
   assign w_drain    = (r_state != ST_EMPTY) && io_bus.out_ready;

   always_comb begin
      w_nxt_state = r_state;
      w_load_new  = 1'b0;
      w_load_tail = 1'b0;
      w_promote   = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_nxt_state = ST_ONE;
               w_load_new  = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_accept && w_drain) begin
               w_load_new = 1'b1;
            end else if (w_accept && (SKID != 0)) begin
               w_nxt_state = ST_TWO;
               w_load_tail = 1'b1;
            end else if (w_drain) begin
               w_nxt_state = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (w_drain) begin
               w_nxt_state = ST_ONE;
               w_promote   = 1'b1;
            end
         end
         default: w_nxt_state = ST_EMPTY;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_nxt_state;
         r_in_ready <= (w_nxt_state != ST_TWO);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_head_imm   <= '0;
         r_head_fmt   <= FMT_NONE;
         r_head_noimm <= 1'b0;
      end else if (w_load_new) begin
         r_head_imm   <= w_imm;
         r_head_fmt   <= w_fmt;
         r_head_noimm <= w_noimm;
      end else if (w_promote) begin
         r_head_imm   <= r_tail_imm;
         r_head_fmt   <= r_tail_fmt;
         r_head_noimm <= r_tail_noimm;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_load_tail) begin
         r_tail_imm   <= w_imm;
         r_tail_fmt   <= w_fmt;
         r_tail_noimm <= w_noimm;
      end
   end

   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_valid = (r_state != ST_EMPTY);
   assign io_bus.out_imm   = r_head_imm;
   assign io_bus.out_fmt   = r_head_fmt;
   assign io_bus.out_noimm = r_head_noimm;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed and randomised-handshake bench for imm_gen_pipe across four parameter sets.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(64)) b_main ();
   imm_gen_pipe_if #(.XLEN(32)) b_x32  ();
   imm_gen_pipe_if #(.XLEN(64)) b_sel  ();
   imm_gen_pipe_if #(.XLEN(64)) b_ns   ();

   imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .SKID(1)) u_main (.i_clk(clk), .i_rst(rst), .io_bus(b_main));
   imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .SKID(1)) u_x32  (.i_clk(clk), .i_rst(rst), .io_bus(b_x32));
   imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(0), .SKID(1)) u_sel  (.i_clk(clk), .i_rst(rst), .io_bus(b_sel));
   imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .SKID(0)) u_ns   (.i_clk(clk), .i_rst(rst), .io_bus(b_ns));

   logic [31:0] t_ins [14];
   logic [67:0] t_exp [14];

   function automatic logic [67:0] ex(input logic n, input logic [2:0] f, input logic [63:0] v);
      return {n, f, v};
   endfunction

   function automatic logic [31:0] addi(input int k);
      return 32'h0000_0093 | (32'(k) << 20);
   endfunction

   task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input int w, input logic v, input logic [31:0] ins,
                        input logic [2:0] sel, input logic ordy);
      case (w)
         0: begin b_main.in_valid = v; b_main.in_instr = ins; b_main.in_sel = sel; b_main.out_ready = ordy; end
         1: begin b_x32.in_valid  = v; b_x32.in_instr  = ins; b_x32.in_sel  = sel; b_x32.out_ready  = ordy; end
         2: begin b_sel.in_valid  = v; b_sel.in_instr  = ins; b_sel.in_sel  = sel; b_sel.out_ready  = ordy; end
         default: begin b_ns.in_valid = v; b_ns.in_instr = ins; b_ns.in_sel = sel; b_ns.out_ready = ordy; end
      endcase
   endtask

   task automatic peek(input int w, output logic irdy, output logic ovld, output logic [67:0] res);
      case (w)
         0: begin irdy = b_main.in_ready; ovld = b_main.out_valid;
                  res = {b_main.out_noimm, b_main.out_fmt, b_main.out_imm}; end
         1: begin irdy = b_x32.in_ready; ovld = b_x32.out_valid;
                  res = {b_x32.out_noimm, b_x32.out_fmt, 32'h0, b_x32.out_imm}; end
         2: begin irdy = b_sel.in_ready; ovld = b_sel.out_valid;
                  res = {b_sel.out_noimm, b_sel.out_fmt, b_sel.out_imm}; end
         default: begin irdy = b_ns.in_ready; ovld = b_ns.out_valid;
                  res = {b_ns.out_noimm, b_ns.out_fmt, b_ns.out_imm}; end
      endcase
   endtask

   task automatic send_chk(input int w, input string tag, input logic [31:0] ins,
                           input logic [2:0] sel, input logic [67:0] exp);
      logic irdy, ovld;
      logic [67:0] res;
      int t;
      drive(w, 1'b0, ins, sel, 1'b1);
      peek(w, irdy, ovld, res);
      t = 0;
      while (!irdy && t < 20) begin
         @(posedge clk); #1;
         peek(w, irdy, ovld, res);
         t++;
      end
      chk({tag, "_rdy"}, 68'(irdy), 68'(1));
      drive(w, 1'b1, ins, sel, 1'b1);
      @(posedge clk); #1;
      drive(w, 1'b0, ins, sel, 1'b1);
      peek(w, irdy, ovld, res);
      chk({tag, "_vld"}, 68'(ovld), 68'(1));
      chk(tag, res, exp);
   endtask

   task automatic bp_test();
      logic irdy, ovld, acc;
      logic [67:0] res;
      int k;
      k = 0;
      drive(0, 1'b1, addi(1), 3'd0, 1'b0);
      for (int c = 0; c < 6; c++) begin
         peek(0, irdy, ovld, res);
         acc = irdy;
         @(posedge clk); #1;
         if (acc) begin k++; drive(0, k < 5, addi(k + 1), 3'd0, 1'b0); end
      end
      peek(0, irdy, ovld, res);
      chk("bp_accepts", 68'(k), 68'(2));
      chk("bp_in_ready", 68'(irdy), 68'(0));
      chk("bp_hold", res, ex(1'b0, 3'd1, 64'd1));
      drive(0, 1'b1, addi(k + 1), 3'd0, 1'b1);
      for (int j = 0; j < 5; j++) begin
         peek(0, irdy, ovld, res);
         chk($sformatf("bp_vld%0d", j), 68'(ovld), 68'(1));
         chk($sformatf("bp_out%0d", j), res, ex(1'b0, 3'd1, 64'(j + 1)));
         acc = irdy && (k < 5);
         @(posedge clk); #1;
         if (acc) begin k++; drive(0, k < 5, addi(k + 1), 3'd0, 1'b1); end
      end
      peek(0, irdy, ovld, res);
      chk("bp_empty", 68'(ovld), 68'(0));
      chk("bp_total", 68'(k), 68'(5));
   endtask

   task automatic rnd_test(input int w, input string tag);
      logic irdy, ovld, pstall, v, ordy;
      logic [67:0] res, pres;
      logic [67:0] q[$];
      int sent, got, cyc, idx;
      sent = 0; got = 0; cyc = 0; pstall = 1'b0; pres = '0;
      drive(w, 1'b0, 32'h0, 3'd0, 1'b0);
      while (got < 1000 && cyc < 20000) begin
         peek(w, irdy, ovld, res);
         if (pstall) begin
            chk({tag, "_hold_v"}, 68'(ovld), 68'(1));
            chk({tag, "_hold"}, res, pres);
         end
         ordy = ($urandom_range(0, 1) == 1);
         idx  = $urandom_range(0, 13);
         v    = (sent < 1000) && ($urandom_range(0, 1) == 1);
         drive(w, 1'b0, t_ins[idx], 3'd0, ordy);
         #1;
         peek(w, irdy, ovld, res);
         drive(w, v, t_ins[idx], 3'd0, ordy);
         if (ovld && ordy) begin
            if (q.size() == 0) chk({tag, "_underflow"}, 68'(q.size()), 68'(1));
            else chk({tag, "_data"}, res, q.pop_front());
            got++;
         end
         if (v && irdy) begin
            q.push_back(t_exp[idx]);
            sent++;
         end
         pstall = ovld && !ordy;
         pres   = res;
         @(posedge clk); #1;
         cyc++;
      end
      drive(w, 1'b0, 32'h0, 3'd0, 1'b1);
      chk({tag, "_count"}, 68'(got), 68'(1000));
      chk({tag, "_left"}, 68'(q.size()), 68'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic irdy, ovld;
      logic [67:0] res;

      t_ins[0]  = 32'h00A00613; t_exp[0]  = ex(1'b0, 3'd1, 64'd10);
      t_ins[1]  = 32'h00001337; t_exp[1]  = ex(1'b0, 3'd2, 64'h1000);
      t_ins[2]  = 32'h00B323A3; t_exp[2]  = ex(1'b0, 3'd3, 64'd7);
      t_ins[3]  = 32'hFEC5CAE3; t_exp[3]  = ex(1'b0, 3'd4, 64'hFFFF_FFFF_FFFF_FFF4);
      t_ins[4]  = 32'h4000006F; t_exp[4]  = ex(1'b0, 3'd5, 64'h400);
      t_ins[5]  = 32'h03F61613; t_exp[5]  = ex(1'b0, 3'd6, 64'd63);
      t_ins[6]  = 32'h340FD073; t_exp[6]  = ex(1'b0, 3'd7, 64'd31);
      t_ins[7]  = 32'h00C58533; t_exp[7]  = ex(1'b1, 3'd0, 64'd0);
      t_ins[8]  = 32'hFFF00093; t_exp[8]  = ex(1'b0, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      t_ins[9]  = 32'h800002B7; t_exp[9]  = ex(1'b0, 3'd2, 64'hFFFF_FFFF_8000_0000);
      t_ins[10] = 32'h03F0109B; t_exp[10] = ex(1'b0, 3'd6, 64'd31);
      t_ins[11] = 32'hC0002573; t_exp[11] = ex(1'b0, 3'd1, 64'hFFFF_FFFF_FFFF_FC00);
      t_ins[12] = 32'h00008067; t_exp[12] = ex(1'b0, 3'd1, 64'd0);
      t_ins[13] = 32'hFE112E23; t_exp[13] = ex(1'b0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC);

      for (int w = 0; w < 4; w++) drive(w, 1'b0, 32'h0, 3'd0, 1'b1);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < 4; w++) begin
         peek(w, irdy, ovld, res);
         chk($sformatf("rst_vld%0d", w), 68'(ovld), 68'(0));
         chk($sformatf("rst_rdy%0d", w), 68'(irdy), 68'(0));
         chk($sformatf("rst_out%0d", w), res, 68'(0));
      end
      rst = 1'b0;
      @(posedge clk); #1;
      for (int w = 0; w < 4; w++) begin
         peek(w, irdy, ovld, res);
         chk($sformatf("rel_rdy%0d", w), 68'(irdy), 68'(1));
      end

      for (int i = 0; i < 14; i++) send_chk(0, $sformatf("main%0d", i), t_ins[i], 3'd0, t_exp[i]);

      send_chk(1, "x32_i",  32'hFFF00093, 3'd0, ex(1'b0, 3'd1, 64'hFFFF_FFFF));
      send_chk(1, "x32_sh", 32'h03F61613, 3'd0, ex(1'b0, 3'd6, 64'd31));
      send_chk(1, "x32_u",  32'h800002B7, 3'd0, ex(1'b0, 3'd2, 64'h8000_0000));
      send_chk(1, "x32_b",  32'hFEC5CAE3, 3'd0, ex(1'b0, 3'd4, 64'hFFFF_FFF4));

      send_chk(2, "sel_s",    32'h00A00613, 3'd3, ex(1'b0, 3'd3, 64'h0C));
      send_chk(2, "sel_none", 32'h00A00613, 3'd0, ex(1'b1, 3'd0, 64'd0));
      send_chk(2, "sel_sh",   32'h03F61613, 3'd6, ex(1'b0, 3'd6, 64'd63));
      send_chk(2, "sel_z",    32'h340FD073, 3'd7, ex(1'b0, 3'd7, 64'd31));
      send_chk(2, "sel_i",    32'h00C58533, 3'd1, ex(1'b0, 3'd1, 64'd12));

      send_chk(3, "ns_b", t_ins[3], 3'd0, t_exp[3]);
      send_chk(3, "ns_j", t_ins[4], 3'd0, t_exp[4]);

      @(posedge clk); #1;
      bp_test();

      rnd_test(0, "rnd_skid");
      rnd_test(3, "rnd_noskid");

      drive(0, 1'b1, addi(7), 3'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      peek(0, irdy, ovld, res);
      chk("two_rdy", 68'(irdy), 68'(0));
      chk("two_vld", 68'(ovld), 68'(1));
      rst = 1'b1;
      drive(0, 1'b0, 32'h0, 3'd0, 1'b0);
      @(posedge clk); #1;
      peek(0, irdy, ovld, res);
      chk("mid_rst_vld", 68'(ovld), 68'(0));
      chk("mid_rst_rdy", 68'(irdy), 68'(0));
      chk("mid_rst_out", res, 68'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      peek(0, irdy, ovld, res);
      chk("post_rst_rdy", 68'(irdy), 68'(1));
      chk("post_rst_vld", 68'(ovld), 68'(0));
      send_chk(0, "post_rst", t_ins[3], 3'd0, t_exp[3]);
      @(posedge clk); #1;
      peek(0, irdy, ovld, res);
      chk("post_rst_empty", 68'(ovld), 68'(0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
